// File: rtl/bus_copy_engine.sv
// bus_copy_engine
//   Word-granular memory copy engine. Acts as the requesting end of the
//   req/ack/resp memory bus and attaches directly to one RAM port. Copies
//   len_bi 32-bit words from src_addr_bi to dst_addr_bi, one outstanding
//   read at a time, and aborts with error_o if a read response never arrives.
//
// Ports
//   clk_i, rst_i            clock (posedge), synchronous active-low reset
//   start_i                 start strobe, only honoured when idle
//   src_addr_bi/dst_addr_bi byte addresses, low two bits ignored
//   len_bi                  number of words to copy
//   busy_o                  job in progress (including the DONE/ERR cycle)
//   done_o / error_o        one-cycle completion / timeout-abort pulses
//   words_done_bo           words written in the current or last job
//   bus_req_o .. bus_wdata_bo  request side of the memory bus (all registered)
//   bus_ack_i               request accepted this cycle
//   bus_resp_i/bus_rdata_bi read data return
module bus_copy_engine #(
    parameter int LEN_WIDTH    = 16,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_bi,
    input  logic [31:0]          dst_addr_bi,
    input  logic [LEN_WIDTH-1:0] len_bi,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [LEN_WIDTH-1:0] words_done_bo,
    output logic                 bus_req_o,
    output logic                 bus_we_o,
    output logic [31:0]          bus_addr_bo,
    output logic [3:0]           bus_be_bo,
    output logic [31:0]          bus_wdata_bo,
    input  logic                 bus_ack_i,
    input  logic                 bus_resp_i,
    input  logic [31:0]          bus_rdata_bi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0]          TIMEOUT   = 16'(RESP_TIMEOUT);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [31:0]          WORD_MASK = 32'hFFFF_FFFC;

    state_t               state_q;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [LEN_WIDTH-1:0] words_done_q;
    logic [15:0]          tmo_q;
    logic [15:0]          tmo_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic                 req_q;
    logic                 we_q;
    logic [31:0]          src_next;
    logic [31:0]          dst_next;

    // Address increments wrap naturally modulo 2^32.
    assign tmo_d    = tmo_q + 16'd1;
    assign src_next = src_q + 32'd4;
    assign dst_next = dst_q + 32'd4;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            tmo_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            // Pulses default low; only the transitions into DONE/ERR raise them.
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        src_q        <= src_addr_bi & WORD_MASK;
                        dst_q        <= dst_addr_bi & WORD_MASK;
                        remaining_q  <= len_bi;
                        words_done_q <= '0;
                        tmo_q        <= '0;
                        busy_q       <= 1'b1;
                        if (len_bi == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD_REQ;
                            req_q   <= 1'b1;
                            we_q    <= 1'b0;
                            addr_q  <= src_addr_bi & WORD_MASK;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (bus_ack_i) begin
                        state_q <= S_RD_WAIT;
                        req_q   <= 1'b0;
                        tmo_q   <= '0;
                    end
                end
                S_RD_WAIT: begin
                    if (bus_resp_i) begin
                        state_q <= S_WR_REQ;
                        wdata_q <= bus_rdata_bi;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= dst_q;
                    end else if (tmo_d == TIMEOUT) begin
                        // RESP_TIMEOUT wait cycles elapsed with no response.
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_WR_REQ: begin
                    if (bus_ack_i) begin
                        src_q        <= src_next;
                        dst_q        <= dst_next;
                        words_done_q <= words_done_q + LEN_ONE;
                        remaining_q  <= remaining_q - LEN_ONE;
                        we_q         <= 1'b0;
                        if (remaining_q == LEN_ONE) begin
                            state_q <= S_DONE;
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // Back-to-back request: req stays high, fields switch to the next read.
                            state_q <= S_RD_REQ;
                            addr_q  <= src_next;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign words_done_bo = words_done_q;
    assign bus_req_o     = req_q;
    assign bus_we_o      = we_q;
    assign bus_addr_bo   = addr_q;
    assign bus_be_bo     = 4'hf;
    assign bus_wdata_bo  = wdata_q;

endmodule

// File: tb/tb_bus_copy_engine.sv
// Testbench for bus_copy_engine: a memory responder with configurable ack
// stalls, response delay and dropped responses, plus a reference model that
// predicts addresses, completion cycle, word count and copied memory contents.
module tb_bus_copy_engine;

    localparam int LW = 16;
    localparam int RT = 8;

    logic          clk;
    logic          rst_i;
    logic          start_i;
    logic [31:0]   src_addr_bi;
    logic [31:0]   dst_addr_bi;
    logic [LW-1:0] len_bi;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [LW-1:0] words_done_bo;
    logic          bus_req_o;
    logic          bus_we_o;
    logic [31:0]   bus_addr_bo;
    logic [3:0]    bus_be_bo;
    logic [31:0]   bus_wdata_bo;
    logic          bus_ack_i;
    logic          bus_resp_i;
    logic [31:0]   bus_rdata_bi;

    bus_copy_engine #(
        .LEN_WIDTH   (LW),
        .RESP_TIMEOUT(RT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .src_addr_bi  (src_addr_bi),
        .dst_addr_bi  (dst_addr_bi),
        .len_bi       (len_bi),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .words_done_bo(words_done_bo),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_bo  (bus_addr_bo),
        .bus_be_bo    (bus_be_bo),
        .bus_wdata_bo (bus_wdata_bo),
        .bus_ack_i    (bus_ack_i),
        .bus_resp_i   (bus_resp_i),
        .bus_rdata_bi (bus_rdata_bi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference memory, word-addressed by byte address.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    // Responder / job state shared with the main sequence.
    logic [31:0] exp_src, exp_dst, resp_addr;
    int          stall_cfg = 0, stall_left = 0, dly_cfg = 0, drop_idx = -1;
    int          rd_idx = 0, wr_idx = 0, resp_wait = 0, drop_ack_cyc = -1, req_cycles = 0;
    bit          outstanding = 0, dropped = 0, prev_stalled = 0, force_spur = 0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;

    // Responder: decides ack/resp for the current cycle on the falling edge.
    initial begin
        logic [31:0] ea;
        bus_ack_i    = 1'b0;
        bus_resp_i   = 1'b0;
        bus_rdata_bi = '0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                bus_ack_i    = 1'b0;
                bus_resp_i   = 1'b0;
                outstanding  = 0;
                prev_stalled = 0;
            end else begin
                if (outstanding && !dropped) begin
                    if (resp_wait == 0) begin
                        bus_resp_i   = 1'b1;
                        bus_rdata_bi = mem_rd(resp_addr);
                        outstanding  = 0;
                    end else begin
                        bus_resp_i   = 1'b0;
                        bus_rdata_bi = $urandom;
                        resp_wait--;
                    end
                end else if (outstanding) begin
                    bus_resp_i = 1'b0;
                end else begin
                    // No read outstanding: stray responses must be ignored.
                    bus_resp_i   = force_spur || ($urandom_range(0, 3) == 0);
                    bus_rdata_bi = $urandom;
                end

                if (prev_stalled) begin
                    check("hold_ctl", {bus_req_o, bus_we_o}, {1'b1, prev_we});
                    check("hold_addr", bus_addr_bo, prev_addr);
                    check("hold_wdata", bus_wdata_bo, prev_wdata);
                end

                if (bus_req_o) begin
                    req_cycles++;
                    if (stall_left > 0) begin
                        bus_ack_i    = 1'b0;
                        stall_left--;
                        prev_stalled = 1;
                        prev_we      = bus_we_o;
                        prev_addr    = bus_addr_bo;
                        prev_wdata   = bus_wdata_bo;
                    end else begin
                        bus_ack_i    = 1'b1;
                        prev_stalled = 0;
                        stall_left   = stall_cfg;
                        check("be", bus_be_bo, 4'hf);
                        if (bus_we_o) begin
                            ea = exp_dst + 32'(4 * wr_idx);
                            check("wr_addr", bus_addr_bo, ea);
                            mem[bus_addr_bo] = bus_wdata_bo;
                            wr_idx++;
                        end else begin
                            ea = exp_src + 32'(4 * rd_idx);
                            check("rd_addr", bus_addr_bo, ea);
                            outstanding = 1;
                            resp_wait   = dly_cfg;
                            resp_addr   = bus_addr_bo;
                            dropped     = (rd_idx == drop_idx);
                            if (dropped) drop_ack_cyc = cyc;
                            rd_idx++;
                        end
                    end
                end else begin
                    bus_ack_i    = 1'b0;
                    prev_stalled = 0;
                end
            end
        end
    end

    task automatic arm(input logic [31:0] src, input logic [31:0] dst, input int stall,
                       input int dly, input int drop);
        exp_src      = src & 32'hFFFF_FFFC;
        exp_dst      = dst & 32'hFFFF_FFFC;
        rd_idx       = 0;
        wr_idx       = 0;
        stall_cfg    = stall;
        stall_left   = stall;
        dly_cfg      = dly;
        drop_idx     = drop;
        outstanding  = 0;
        dropped      = 0;
        req_cycles   = 0;
        drop_ack_cyc = -1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, {busy_o, done_o, error_o, bus_req_o, bus_we_o}, 5'b0);
        check({tag, "_addr"}, bus_addr_bo, 32'h0);
        check({tag, "_wdata"}, bus_wdata_bo, 32'h0);
        check({tag, "_words"}, words_done_bo, 16'h0);
        check({tag, "_be"}, bus_be_bo, 4'hf);
    endtask

    // One copy job: preload source, start, follow to done/error, compare with model.
    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input int stall, input int dly, input int drop,
                           input bit use_pat, input logic [31:0] pat);
        logic [31:0] sbase, dbase, a;
        logic [31:0] vals[$];
        int          t, exp_end, n_ok;
        bit          seen;
        sbase = src & 32'hFFFF_FFFC;
        dbase = dst & 32'hFFFF_FFFC;
        for (int i = 0; i < len; i++) begin
            a = sbase + 32'(4 * i);
            mem[a] = use_pat ? pat + 32'(i) : $urandom;
            vals.push_back(mem[a]);
        end
        @(negedge clk);
        arm(src, dst, stall, dly, drop);
        start_i     = 1'b1;
        src_addr_bi = src;
        dst_addr_bi = dst;
        len_bi      = LW'(len);
        t           = cyc;
        @(negedge clk);
        start_i     = 1'b0;
        src_addr_bi = $urandom;
        dst_addr_bi = $urandom;
        len_bi      = LW'($urandom_range(1, 9));
        check("busy_start", busy_o, 1'b1);
        if (len > 0) check("req_start", bus_req_o, 1'b1);
        exp_end = t + 1 + len * (2 * (1 + stall) + 1 + dly);
        seen = 0;
        for (int k = 0; k < 400; k++) begin
            if (done_o || error_o) begin
                seen = 1;
                break;
            end
            // A start strobe mid-job must be ignored.
            start_i = (k == 1 && len > 0);
            @(negedge clk);
        end
        start_i = 1'b0;
        check("job_end_seen", seen, 1'b1);
        if (drop < 0) begin
            check("done_pulse", {done_o, error_o}, 2'b10);
            check("done_cycle", cyc, exp_end);
            check("words_done", words_done_bo, LW'(len));
            n_ok = len;
        end else begin
            check("err_pulse", {done_o, error_o}, 2'b01);
            check("err_cycle", cyc, drop_ack_cyc + 1 + RT);
            check("words_at_err", words_done_bo, LW'(drop));
            n_ok = drop;
        end
        if (len == 0) check("no_req", req_cycles, 0);
        @(negedge clk);
        check("idle_after", {busy_o, done_o, error_o, bus_req_o}, 4'b0);
        check("words_hold", words_done_bo, LW'(n_ok));
        for (int i = 0; i < n_ok; i++) begin
            a = dbase + 32'(4 * i);
            check("mem_copy", mem_rd(a), vals[i]);
        end
    endtask

    initial begin
        int          t, len, drop;
        logic [31:0] s, d;
        rst_i       = 1'b0;
        start_i     = 1'b0;
        src_addr_bi = '0;
        dst_addr_bi = '0;
        len_bi      = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_i = 1'b1;

        // Basic copy, zero-wait responder.
        run_job(32'h100, 32'h200, 4, 0, 0, -1, 1, 32'hA0);
        // Zero-length job.
        run_job(32'h400, 32'h500, 0, 0, 0, -1, 0, 32'h0);
        // Two-cycle ack stall on every request.
        run_job(32'h600, 32'h700, 2, 2, 0, -1, 0, 32'h0);
        // Missing response on the second read.
        run_job(32'h800, 32'h900, 3, 0, 0, 1, 0, 32'h0);
        // Unaligned source at the top of the address space wraps to 0.
        run_job(32'hFFFF_FFFE, 32'h10, 2, 0, 0, -1, 0, 32'h0);

        // Reset during the second word's read wait.
        for (int i = 0; i < 3; i++) mem[32'h3000 + 32'(4 * i)] = $urandom;
        @(negedge clk);
        arm(32'h3000, 32'h3100, 0, 0, -1);
        start_i     = 1'b1;
        src_addr_bi = 32'h3000;
        dst_addr_bi = 32'h3100;
        len_bi      = 16'd3;
        t           = cyc;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 20 && cyc < t + 5; k++) @(negedge clk);
        check("rst_mid_rdidx", rd_idx, 2);
        check("rst_mid_busy", busy_o, 1'b1);
        rst_i = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        rst_i      = 1'b1;
        force_spur = 1;
        repeat (4) @(negedge clk);
        force_spur = 0;
        check("spur_idle", {busy_o, bus_req_o, done_o, error_o}, 4'b0);
        check("spur_words", words_done_bo, 16'h0);
        run_job(32'h3000, 32'h3200, 3, 0, 0, -1, 0, 32'h0);

        // Randomized jobs: alignment, length, stalls, delays, occasional drop.
        for (int j = 0; j < 10; j++) begin
            s    = 32'h1000_0000 + ($urandom_range(0, 255) << 8) + $urandom_range(0, 3);
            d    = 32'h2000_0000 + ($urandom_range(0, 255) << 8) + $urandom_range(0, 3);
            len  = $urandom_range(1, 6);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            run_job(s, d, len, $urandom_range(0, 2), $urandom_range(0, 3), drop, 0, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
